// File: rtl/zap_predecode_coproc_mc.sv
// zap_predecode_coproc_mc
// Coprocessor gate between predecode and decode. Detects MRC/MCR/LDC/STC/CDP
// (and their cond=1111 "*2" forms), checks the coprocessor number against
// the attach and user-access masks, drains the pipeline, then hands the
// instruction word to one of 16 coprocessors through a one-hot select.
// Denied accesses raise o_und instead of being forwarded.
//
// Optional build macro: ZAP_COPRO_TIMEOUT_EN
//   Adds a BUSY watchdog of TIMEOUT enabled cycles. On expiry without done,
//   the stall releases and o_und is raised so decode takes an undefined trap.
//
// Coprocessor handshake: o_copro_dav_nxt/o_copro_sel_nxt/o_copro_word_nxt are
// the next-state values of the request registers. A request stays asserted
// until the selected coprocessor raises its i_copro_done bit; the coprocessor
// holds done until it sees dav low. Done bits of unselected coprocessors are
// ignored. Dropping dav without done (pipeline clear) aborts the operation.
//
// o_dbg_state exposes the FSM state (0 = IDLE, 1 = BUSY).

module zap_predecode_coproc_mc #(
    parameter logic [31:0] PHY_REGS    = 32'd46,
    parameter logic [15:0] CP_EN_MASK  = 16'h8000,
    parameter logic [15:0] CP_USR_MASK = 16'h0000,
    parameter logic [31:0] TIMEOUT     = 32'd255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [34:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_cpsr_ff_t,
    input  logic [4:0]  i_cpsr_ff_mode,
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_clear_from_decode,
    input  logic        i_pipeline_dav,
    input  logic [15:0] i_copro_done,
    output logic        o_irq,
    output logic        o_fiq,
    output logic [34:0] o_instruction,
    output logic        o_valid,
    output logic        o_und,
    output logic        o_stall_from_decode,
    output logic        o_copro_dav_nxt,
    output logic [15:0] o_copro_sel_nxt,
    output logic [31:0] o_copro_word_nxt,
    output logic        o_dbg_state
);

    localparam logic [4:0] USR = 5'h10;

    typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;

    state_t      state_ff, state_nxt;
    logic        dav_ff, dav_nxt;
    logic [15:0] sel_ff, sel_nxt;
    logic [31:0] word_ff, word_nxt;

    logic        is_copro, hit, allowed, done, expire, clear, enable;
    logic [3:0]  cp_num;

    // PHY_REGS is kept only for drop-in instantiation compatibility.
    logic unused_params;
    assign unused_params = ^{PHY_REGS, TIMEOUT};

    assign o_instruction = i_instruction;
    assign o_valid       = i_valid;
    assign o_dbg_state   = state_ff;

    // MRC/MCR/CDP share 1110 in [27:24]; LDC/STC (and MCRR/MRRC) have 110 in [27:25].
    assign is_copro = (i_instruction[27:24] == 4'b1110) || (i_instruction[27:25] == 3'b110);
    assign hit      = !i_cpsr_ff_t && (i_instruction[34:32] == 3'd0) && i_valid && is_copro;
    assign cp_num   = i_instruction[11:8];
    assign allowed  = CP_EN_MASK[cp_num] && ((i_cpsr_ff_mode != USR) || CP_USR_MASK[cp_num]);
    assign done     = |(i_copro_done & sel_ff);

    assign clear  = i_clear_from_writeback
                  | (i_clear_from_alu & !i_data_stall)
                  | (i_clear_from_decode & !i_data_stall & !i_stall_from_shifter & !i_stall_from_issue);
    assign enable = !i_data_stall & !i_stall_from_shifter & !i_stall_from_issue;

`ifdef ZAP_COPRO_TIMEOUT_EN
    localparam int WDW = (TIMEOUT == 32'd0) ? 1 : $clog2({1'b0, TIMEOUT} + 33'd1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 32'd1);

    logic [WDW-1:0] wdog_ff;

    // Watchdog counts enabled BUSY cycles; restarts from 0 whenever idle.
    always_ff @(posedge i_clk) begin
        if (i_reset || clear) begin
            wdog_ff <= '0;
        end else if (enable) begin
            if (state_ff == IDLE) wdog_ff <= '0;
            else                  wdog_ff <= wdog_ff + WDW'(1);
        end
    end

    assign expire = (TIMEOUT != 32'd0) && (state_ff == BUSY) && (wdog_ff == WD_LAST) && !done;
`else
    assign expire = 1'b0;
`endif

    // Next-state and gate outputs; done takes priority over watchdog expiry.
    always_comb begin
        state_nxt           = state_ff;
        dav_nxt             = dav_ff;
        sel_nxt             = sel_ff;
        word_nxt            = word_ff;
        o_stall_from_decode = 1'b0;
        o_und               = 1'b0;
        o_irq               = i_irq;
        o_fiq               = i_fiq;

        case (state_ff)
            IDLE: begin
                dav_nxt  = 1'b0;
                sel_nxt  = 16'd0;
                word_nxt = 32'd0;
                if (hit && !allowed) begin
                    o_und = 1'b1;
                end else if (hit) begin
                    o_stall_from_decode = 1'b1;
                    o_irq               = 1'b0;
                    o_fiq               = 1'b0;
                    if (!i_pipeline_dav) begin
                        state_nxt = BUSY;
                        dav_nxt   = 1'b1;
                        sel_nxt   = 16'd1 << cp_num;
                        word_nxt  = i_instruction[31:0];
                    end
                end
            end
            BUSY: begin
                o_stall_from_decode = 1'b1;
                o_irq               = 1'b0;
                o_fiq               = 1'b0;
                if (done || expire) begin
                    o_stall_from_decode = 1'b0;
                    o_und               = expire;
                    state_nxt           = IDLE;
                    dav_nxt             = 1'b0;
                    sel_nxt             = 16'd0;
                    word_nxt            = 32'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_copro_dav_nxt  = dav_nxt;
    assign o_copro_sel_nxt  = sel_nxt;
    assign o_copro_word_nxt = word_nxt;

    // Request registers: reset/clear, then load when no stall, else hold.
    always_ff @(posedge i_clk) begin
        if (i_reset || clear) begin
            state_ff <= IDLE;
            dav_ff   <= 1'b0;
            sel_ff   <= 16'd0;
            word_ff  <= 32'd0;
        end else if (enable) begin
            state_ff <= state_nxt;
            dav_ff   <= dav_nxt;
            sel_ff   <= sel_nxt;
            word_ff  <= word_nxt;
        end
    end

endmodule
